// File: rtl/controlador_atributos_n_pkg.sv
// Shared Tamagotchi definitions: one-hot pet-state codes, default attribute indices
// and the saturating rise/decay rules applied by the attribute engine.
package tamagotchi_pkg;

    localparam logic [4:0] ST_INTRO      = 5'd0;
    localparam logic [4:0] ST_IDLE       = 5'd1;
    localparam logic [4:0] ST_DORMINDO   = 5'd2;
    localparam logic [4:0] ST_COMENDO    = 5'd4;
    localparam logic [4:0] ST_DANDO_AULA = 5'd8;
    localparam logic [4:0] ST_MORTO      = 5'd16;

    localparam int FOME       = 0;
    localparam int FELICIDADE = 1;
    localparam int SONO       = 2;

    typedef enum logic [1:0] {
        UPD_HOLD,
        UPD_RISE,
        UPD_DECAY
    } upd_mode_e;

    // Evaluated at 32 bits so the caller can use any attribute width up to 31.
    function automatic logic [31:0] sat_rise(input logic [31:0] a,
                                             input logic [31:0] max_v,
                                             input logic [31:0] vel);
        return (a > max_v - vel) ? max_v : a + vel;
    endfunction

    function automatic logic [31:0] sat_decay(input logic [31:0] a,
                                              input logic [31:0] vel);
        return (a <= vel) ? 32'd0 : a - vel;
    endfunction

endpackage

// File: rtl/controlador_atributos_n_if.sv
// Valid/ready boost channel used by game events to add one-shot increments to an attribute.
interface controlador_atributos_n_if #(
    parameter int NUM_ATTR = 3,
    parameter int ATTR_W   = 8
);
    localparam int IDX_W = (NUM_ATTR > 1) ? $clog2(NUM_ATTR) : 1;

    logic              boost_valid;
    logic [IDX_W-1:0]  boost_idx;
    logic [ATTR_W-1:0] boost_amt;
    logic              boost_ready;

    modport master (output boost_valid, output boost_idx, output boost_amt, input boost_ready);
    modport slave  (input boost_valid, input boost_idx, input boost_amt, output boost_ready);
endinterface

// File: rtl/controlador_atributos_n_gerador_tick.sv
// Free-running prescaler: counts 0..TICK_DIV-1 and flags the last count as the update tick.
module gerador_tick #(
    parameter int TICK_DIV = 8388608
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    localparam int              CNT_W    = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick  = (cnt_q == CNT_LAST);
    assign cnt_d = tick ? '0 : cnt_q + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/controlador_atributos_n.sv
// Attribute engine: NUM_ATTR saturating counters updated per tick by pet state, plus boost port.
// Optional starvation detector enabled by defining ATTR_CRIT_EN.
module controlador_atributos_n
    import tamagotchi_pkg::*;
#(
    parameter int NUM_ATTR     = 3,
    parameter int ATTR_W       = 8,
    parameter int TICK_DIV     = 8388608,
    parameter int ATTR_MAX     = 100,
    parameter int VEL_UP       = 3,
    parameter int VEL_DOWN     = 1,
    parameter logic [NUM_ATTR*ATTR_W-1:0] INIT_VALS = {8'd50, 8'd70, 8'd80},
    parameter int IDX_COMENDO  = FOME,
    parameter int IDX_AULA     = FELICIDADE,
    parameter int IDX_DORMINDO = SONO,
    parameter int CRIT_TICKS   = 3,
    localparam int IDX_W       = (NUM_ATTR > 1) ? $clog2(NUM_ATTR) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [4:0]                 estado,
    controlador_atributos_n_if.slave   boost,
    output logic [NUM_ATTR*ATTR_W-1:0] attrs,
    output logic                       tick,
    output logic                       critical,
    output logic [IDX_W-1:0]           crit_idx
);
    logic                boost_acc;
    logic [NUM_ATTR-1:0] boost_hit;

    gerador_tick #(.TICK_DIV(TICK_DIV)) u_gerador_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // Tick has priority: ready drops on the tick cycle so a pending boost waits one cycle.
    assign boost.boost_ready = rst_n & ~tick;
    assign boost_acc         = boost.boost_valid & boost.boost_ready;

`ifdef ATTR_CRIT_EN
    localparam int ZR_W = $clog2(CRIT_TICKS + 1);
    logic [NUM_ATTR-1:0] crit_hit;
    logic [NUM_ATTR-1:0] post_nz;
`endif

    generate
        for (genvar gi = 0; gi < NUM_ATTR; gi++) begin : g_ch
            logic [ATTR_W-1:0] attr_q;
            logic [ATTR_W-1:0] attr_d;
            logic [ATTR_W:0]   boost_sum;
            upd_mode_e         mode;

            always_comb begin
                mode = UPD_DECAY;
                case (estado)
                    ST_INTRO, ST_MORTO: mode = UPD_HOLD;
                    ST_COMENDO:         mode = (gi == IDX_COMENDO)  ? UPD_RISE : UPD_DECAY;
                    ST_DANDO_AULA:      mode = (gi == IDX_AULA)     ? UPD_RISE : UPD_DECAY;
                    ST_DORMINDO:        mode = (gi == IDX_DORMINDO) ? UPD_RISE : UPD_DECAY;
                    default:            mode = UPD_DECAY;
                endcase
            end

            assign boost_hit[gi] = boost_acc && (int'(boost.boost_idx) == gi);
            assign boost_sum     = {1'b0, attr_q} + {1'b0, boost.boost_amt};

            always_comb begin
                attr_d = attr_q;
                if (tick) begin
                    case (mode)
                        UPD_RISE:  attr_d = ATTR_W'(sat_rise(32'(attr_q), 32'(ATTR_MAX), 32'(VEL_UP)));
                        UPD_DECAY: attr_d = ATTR_W'(sat_decay(32'(attr_q), 32'(VEL_DOWN)));
                        default:   attr_d = attr_q;
                    endcase
                end else if (boost_hit[gi]) begin
                    attr_d = (boost_sum > (ATTR_W+1)'(ATTR_MAX)) ? ATTR_W'(ATTR_MAX)
                                                                 : boost_sum[ATTR_W-1:0];
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) attr_q <= INIT_VALS[gi*ATTR_W +: ATTR_W];
                else        attr_q <= attr_d;
            end

            assign attrs[gi*ATTR_W +: ATTR_W] = attr_q;

`ifdef ATTR_CRIT_EN
            logic [ZR_W-1:0] zrun_q;
            logic [ZR_W-1:0] zrun_d;

            // Run length saturates at CRIT_TICKS so a long starvation never wraps back to zero.
            always_comb begin
                zrun_d = zrun_q;
                if (tick) begin
                    if (attr_d != '0)                         zrun_d = '0;
                    else if (zrun_q != ZR_W'(CRIT_TICKS))     zrun_d = zrun_q + ZR_W'(1);
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) zrun_q <= '0;
                else        zrun_q <= zrun_d;
            end

            assign crit_hit[gi] = tick && (zrun_d == ZR_W'(CRIT_TICKS));
            assign post_nz[gi]  = (attr_d != '0);
`endif
        end
    endgenerate

`ifdef ATTR_CRIT_EN
    logic             critical_q;
    logic             critical_d;
    logic [IDX_W-1:0] crit_idx_q;
    logic [IDX_W-1:0] crit_idx_d;

    always_comb begin
        critical_d = critical_q;
        crit_idx_d = crit_idx_q;
        if (!critical_q && (|crit_hit)) begin
            critical_d = 1'b1;
            for (int i = NUM_ATTR - 1; i >= 0; i--) begin
                if (crit_hit[i]) crit_idx_d = IDX_W'(i);
            end
        end else if (critical_q && (boost.boost_idx == crit_idx_q) && (|(boost_hit & post_nz))) begin
            critical_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            critical_q <= 1'b0;
            crit_idx_q <= '0;
        end else begin
            critical_q <= critical_d;
            crit_idx_q <= crit_idx_d;
        end
    end

    assign critical = critical_q;
    assign crit_idx = crit_idx_q;
`else
    assign critical = 1'b0;
    assign crit_idx = '0;
`endif
endmodule

// File: tb/tb_controlador_atributos_n.sv
// Directed bench for controlador_atributos_n with TICK_DIV=4 and hand-computed attribute values.
module tb_controlador_atributos_n;
    import tamagotchi_pkg::*;

`ifdef ATTR_CRIT_EN
    localparam bit CRIT_ON = 1'b1;
`else
    localparam bit CRIT_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  estado;
    logic [23:0] attrs;
    logic        tick;
    logic        critical;
    logic [1:0]  crit_idx;
    int          n_checks = 0;
    int          n_pass   = 0;

    controlador_atributos_n_if #(.NUM_ATTR(3), .ATTR_W(8)) bif ();

    controlador_atributos_n #(.TICK_DIV(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .estado   (estado),
        .boost    (bif.slave),
        .attrs    (attrs),
        .tick     (tick),
        .critical (critical),
        .crit_idx (crit_idx)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    function automatic logic [7:0] attr_at(input int i);
        return attrs[i*8 +: 8];
    endfunction

    task automatic check_attrs(input string tag, input int f, input int h, input int s);
        check_eq({tag, ".fome"},       32'(attr_at(0)), 32'(f));
        check_eq({tag, ".felicidade"}, 32'(attr_at(1)), 32'(h));
        check_eq({tag, ".sono"},       32'(attr_at(2)), 32'(s));
    endtask

    task automatic wait_tick();
        int guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (tick !== 1'b1 && guard < 8);
        if (tick !== 1'b1) check_eq("tick_timeout", 32'(tick), 32'd1);
    endtask

    task automatic tick_update();
        wait_tick();
        @(negedge clk);
    endtask

    task automatic do_boost(input int idx, input int amt);
        int guard = 0;
        bif.boost_valid = 1'b1;
        bif.boost_idx   = 2'(idx);
        bif.boost_amt   = 8'(amt);
        while (bif.boost_ready !== 1'b1 && guard < 4) begin
            @(negedge clk);
            guard++;
        end
        if (bif.boost_ready !== 1'b1) check_eq("boost_ready_timeout", 32'(bif.boost_ready), 32'd1);
        @(negedge clk);
        bif.boost_valid = 1'b0;
        $display("boost idx=%0d amt=%0d -> attrs %0d/%0d/%0d crit=%0d",
                 idx, amt, attr_at(0), attr_at(1), attr_at(2), critical);
    endtask

    initial begin
        rst_n           = 1'b0;
        estado          = ST_INTRO;
        bif.boost_valid = 1'b0;
        bif.boost_idx   = '0;
        bif.boost_amt   = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check_attrs("reset", 80, 70, 50);
        check_eq("reset.tick", 32'(tick), 32'd0);
        check_eq("reset.critical", 32'(critical), 32'd0);
        check_eq("reset.crit_idx", 32'(crit_idx), 32'd0);
        check_eq("reset.boost_ready", 32'(bif.boost_ready), 32'd0);

        // Release, then reset again mid-count right on a tick cycle
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("pre_reset.tick", 32'(tick), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_eq("async_reset.tick", 32'(tick), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            check_eq($sformatf("first_tick.cyc%0d", i), 32'(tick), (i == 3) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        check_attrs("intro_tick", 80, 70, 50);
        check_eq("intro_tick.ready", 32'(bif.boost_ready), 32'd1);

        // COMENDO: fome rises, others decay; then saturation at ATTR_MAX
        estado = ST_COMENDO;
        tick_update(); $display("tick COMENDO -> %0d/%0d/%0d", attr_at(0), attr_at(1), attr_at(2));
        check_attrs("comendo1", 83, 69, 49);
        tick_update(); $display("tick COMENDO -> %0d/%0d/%0d", attr_at(0), attr_at(1), attr_at(2));
        check_attrs("comendo2", 86, 68, 48);
        do_boost(0, 13);
        check_attrs("preload99", 99, 68, 48);
        tick_update();
        check_attrs("comendo_sat", 100, 67, 47);
        tick_update();
        check_attrs("comendo_hold", 100, 66, 46);

        // MORTO and INTRO hold everything while ticks keep pulsing
        estado = ST_MORTO;
        for (int i = 0; i < 10; i++) begin
            wait_tick();
            check_eq($sformatf("morto.tick%0d", i), 32'(tick), 32'd1);
        end
        @(negedge clk);
        check_attrs("morto", 100, 66, 46);
        estado = ST_INTRO;
        repeat (2) tick_update();
        check_attrs("intro", 100, 66, 46);

        estado = ST_DANDO_AULA;
        tick_update();
        check_attrs("aula", 99, 69, 45);
        estado = ST_DORMINDO;
        tick_update();
        check_attrs("dormindo", 98, 68, 48);

        // IDLE decay to zero without underflow, starvation detection
        estado = ST_IDLE;
        repeat (47) tick_update();
        check_attrs("idle47", 51, 21, 1);
        check_eq("idle47.critical", 32'(critical), 32'd0);
        tick_update();
        check_attrs("idle48", 50, 20, 0);
        check_eq("idle48.critical", 32'(critical), 32'd0);
        tick_update();
        check_eq("idle49.critical", 32'(critical), 32'd0);
        tick_update();
        check_attrs("idle50", 48, 18, 0);
        check_eq("idle50.critical", 32'(critical), 32'(CRIT_ON));
        check_eq("idle50.crit_idx", 32'(crit_idx), CRIT_ON ? 32'd2 : 32'd0);
        repeat (17) tick_update();
        check_attrs("idle67", 31, 1, 0);
        tick_update();
        check_attrs("idle68", 30, 0, 0);
        check_eq("idle68.critical", 32'(critical), 32'(CRIT_ON));

        do_boost(2, 5);
        check_attrs("rescue_sono", 30, 0, 5);
        check_eq("rescue_sono.critical", 32'(critical), 32'd0);
        tick_update();
        check_attrs("idle69", 29, 0, 4);
        check_eq("idle69.critical", 32'(critical), 32'd0);
        tick_update();
        check_attrs("idle70", 28, 0, 3);
        check_eq("idle70.critical", 32'(critical), 32'(CRIT_ON));
        check_eq("idle70.crit_idx", 32'(crit_idx), CRIT_ON ? 32'd1 : 32'd0);
        do_boost(2, 1);
        check_eq("other_idx.critical", 32'(critical), 32'(CRIT_ON));
        do_boost(1, 0);
        check_eq("zero_amt.felicidade", 32'(attr_at(1)), 32'd0);
        check_eq("zero_amt.critical", 32'(critical), 32'(CRIT_ON));
        do_boost(1, 50);
        check_attrs("rescue_fel", 28, 50, 4);
        check_eq("rescue_fel.critical", 32'(critical), 32'd0);

        // Boost saturation, wide-sum without wrap, out-of-range index, collision with tick
        estado = ST_INTRO;
        do_boost(1, 60);
        check_eq("boost_sat.felicidade", 32'(attr_at(1)), 32'd100);
        do_boost(0, 255);
        check_eq("boost_nowrap.fome", 32'(attr_at(0)), 32'd100);
        do_boost(3, 10);
        check_attrs("boost_idx3", 100, 100, 4);
        wait_tick();
        bif.boost_valid = 1'b1;
        bif.boost_idx   = 2'd2;
        bif.boost_amt   = 8'd5;
        #1 check_eq("collide.ready", 32'(bif.boost_ready), 32'd0);
        @(negedge clk);
        check_eq("collide.sono_held", 32'(attr_at(2)), 32'd4);
        check_eq("collide.ready_next", 32'(bif.boost_ready), 32'd1);
        @(negedge clk);
        bif.boost_valid = 1'b0;
        $display("boost idx=2 amt=5 (after tick) -> sono %0d", attr_at(2));
        check_eq("collide.sono", 32'(attr_at(2)), 32'd9);

        // Asynchronous reset restores values without a clock edge
        #2 rst_n = 1'b0;
        #1;
        check_attrs("final_reset", 80, 70, 50);
        check_eq("final_reset.ready", 32'(bif.boost_ready), 32'd0);
        check_eq("final_reset.tick", 32'(tick), 32'd0);
        check_eq("final_reset.critical", 32'(critical), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
